// File: rtl/mips789_ctl_pkg.sv
// Shared types and constants for the mips789 forwarding/hazard control.
// Select codes mirror the FW_* values used by the exec_stage muxes.
package mips789_ctl_pkg;

    localparam logic [2:0] FW_NOP = 3'd0;
    localparam logic [2:0] FW_ALU = 3'd1;
    localparam logic [2:0] FW_MEM = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        LD_STALL,
        MD_WAIT
    } fsm_t;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic       load;
    } dst_sh_t;

endpackage

// File: rtl/fw_match.sv
// Forward-source match for one ID source register against EX and MEM.
// EX wins over MEM because it holds the younger write.
module fw_match
    import mips789_ctl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       used,
    input  dst_sh_t    ex_sh,
    input  dst_sh_t    mem_sh,
    output logic [2:0] fw
);

    logic unused_load;
    assign unused_load = ex_sh.load ^ mem_sh.load;

    always_comb begin
        fw = FW_NOP;
        if (used && src != 5'd0) begin
            if (ex_sh.we && ex_sh.addr == src)
                fw = FW_ALU;
            else if (mem_sh.we && mem_sh.addr == src)
                fw = FW_MEM;
        end
    end

endmodule

// File: rtl/fw_hazard_ctl.sv
// Operand-forwarding select generation and load-use / mul-div stall
// sequencing for the mips789 exec_stage.
module fw_hazard_ctl
    import mips789_ctl_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       id_rs_used,
    input  logic       id_rt_used,
    input  logic       id_rt_is_store,
    input  logic       id_wb_we,
    input  logic [4:0] id_wb_addr,
    input  logic       id_is_load,
    input  logic       id_is_muldiv,
    input  logic       id_reads_hilo,
    input  logic       flush,
    output logic [2:0] muxa_fw_ctl,
    output logic [2:0] muxb_fw_ctl,
    output logic [2:0] dmem_fw_ctl,
    output logic       pause,
    output logic       ex_bubble,
    output logic       md_busy
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    dst_sh_t       ex_sh;
    dst_sh_t       mem_sh;
    fsm_t          state;
    fsm_t          state_nx;
    logic [CW-1:0] md_cnt;
    logic [2:0]    rs_fw;
    logic [2:0]    rt_fw;
    logic          load_use;
    logic          md_haz;
    logic          issue;

    fw_match u_rs (
        .src    (id_rs_addr),
        .used   (id_rs_used),
        .ex_sh  (ex_sh),
        .mem_sh (mem_sh),
        .fw     (rs_fw)
    );

    fw_match u_rt (
        .src    (id_rt_addr),
        .used   (id_rt_used),
        .ex_sh  (ex_sh),
        .mem_sh (mem_sh),
        .fw     (rt_fw)
    );

    assign md_busy  = (md_cnt != '0);
    assign load_use = id_valid & ex_sh.load
                    & ((rs_fw == FW_ALU) | (rt_fw == FW_ALU));
    assign md_haz   = id_valid & md_busy
                    & (id_reads_hilo | id_is_muldiv);

    // Flush kills the ID instruction, so there is nothing left to hold.
    assign pause     = ~flush & (md_haz | load_use);
    assign ex_bubble = pause;
    assign issue     = id_valid & ~pause & ~flush;

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (md_haz)
                        state_nx = MD_WAIT;
                    else if (load_use)
                        state_nx = LD_STALL;
                end
                LD_STALL: state_nx = IDLE;
                MD_WAIT: begin
                    if (md_cnt == '0)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ex_sh       <= '0;
            mem_sh      <= '0;
            md_cnt      <= '0;
            muxa_fw_ctl <= FW_NOP;
            muxb_fw_ctl <= FW_NOP;
            dmem_fw_ctl <= FW_NOP;
        end else begin
            state  <= state_nx;
            mem_sh <= ex_sh;
            if (issue)
                ex_sh <= '{we: id_wb_we, addr: id_wb_addr, load: id_is_load};
            else
                ex_sh <= '0;

            // The mul/div unit cannot abort, so flush does not stop the count.
            if (issue && id_is_muldiv)
                md_cnt <= CW'(MD_CYCLES);
            else if (md_cnt != '0)
                md_cnt <= md_cnt - 1'b1;

            if (issue) begin
                muxa_fw_ctl <= rs_fw;
                muxb_fw_ctl <= id_rt_is_store ? FW_NOP : rt_fw;
                dmem_fw_ctl <= id_rt_is_store ? rt_fw : FW_NOP;
            end else begin
                muxa_fw_ctl <= FW_NOP;
                muxb_fw_ctl <= FW_NOP;
                dmem_fw_ctl <= FW_NOP;
            end
        end
    end

endmodule

// File: tb/tb_fw_hazard_ctl.sv
// Bench for fw_hazard_ctl: directed pipeline sequences plus a
// randomized run against a program-order reference model.
module tb_fw_hazard_ctl;
    import mips789_ctl_pkg::*;

    localparam int MDC = 4;

    typedef struct packed {
        bit       v;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       rsu;
        bit       rtu;
        bit       st;
        bit       we;
        bit [4:0] wb;
        bit       ld;
        bit       md;
        bit       hl;
    } ins_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_rt_is_store;
    logic       id_wb_we;
    logic [4:0] id_wb_addr;
    logic       id_is_load;
    logic       id_is_muldiv;
    logic       id_reads_hilo;
    logic       flush;
    logic [2:0] muxa_fw_ctl;
    logic [2:0] muxb_fw_ctl;
    logic [2:0] dmem_fw_ctl;
    logic       pause;
    logic       ex_bubble;
    logic       md_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fw_hazard_ctl #(.MD_CYCLES(MDC)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs_addr     (id_rs_addr),
        .id_rt_addr     (id_rt_addr),
        .id_rs_used     (id_rs_used),
        .id_rt_used     (id_rt_used),
        .id_rt_is_store (id_rt_is_store),
        .id_wb_we       (id_wb_we),
        .id_wb_addr     (id_wb_addr),
        .id_is_load     (id_is_load),
        .id_is_muldiv   (id_is_muldiv),
        .id_reads_hilo  (id_reads_hilo),
        .flush          (flush),
        .muxa_fw_ctl    (muxa_fw_ctl),
        .muxb_fw_ctl    (muxb_fw_ctl),
        .dmem_fw_ctl    (dmem_fw_ctl),
        .pause          (pause),
        .ex_bubble      (ex_bubble),
        .md_busy        (md_busy)
    );

    function automatic ins_t nop();
        ins_t i = '0;
        return i;
    endfunction

    function automatic ins_t alu(bit [4:0] d, bit [4:0] s, bit [4:0] t);
        ins_t i = '0;
        i.v = 1; i.rs = s; i.rt = t; i.rsu = 1; i.rtu = 1;
        i.we = 1; i.wb = d;
        return i;
    endfunction

    task automatic put(input ins_t i);
        id_valid       = i.v;
        id_rs_addr     = i.rs;
        id_rt_addr     = i.rt;
        id_rs_used     = i.rsu;
        id_rt_used     = i.rtu;
        id_rt_is_store = i.st;
        id_wb_we       = i.we;
        id_wb_addr     = i.wb;
        id_is_load     = i.ld;
        id_is_muldiv   = i.md;
        id_reads_hilo  = i.hl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        put(nop());
        flush = 0;
        repeat (n) cyc();
    endtask

    task automatic chk(input string nm, input logic [2:0] got,
                       input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        flush = 0;
        put(nop());
        #2;
        chk("rst_muxa", muxa_fw_ctl, FW_NOP);
        chk("rst_muxb", muxb_fw_ctl, FW_NOP);
        chk("rst_dmem", dmem_fw_ctl, FW_NOP);
        chk("rst_pause", {2'b0, pause}, 3'd0);
        chk("rst_bubble", {2'b0, ex_bubble}, 3'd0);
        chk("rst_busy", {2'b0, md_busy}, 3'd0);
        cyc();
        rst = 0;
        idle(2);
    endtask

    task automatic test_back_to_back();
        idle(2);
        put(alu(3, 1, 2));
        cyc();
        put(alu(4, 3, 5));
        @(negedge clk);
        chk("b2b_pause", {2'b0, pause}, 3'd0);
        cyc();
        put(nop());
        @(negedge clk);
        chk("b2b_muxa", muxa_fw_ctl, FW_ALU);
        chk("b2b_muxb", muxb_fw_ctl, FW_NOP);
    endtask

    task automatic test_one_gap();
        idle(2);
        put(alu(3, 1, 2));
        cyc();
        put(nop());
        cyc();
        put(alu(6, 3, 0));
        cyc();
        put(nop());
        @(negedge clk);
        chk("gap_muxa", muxa_fw_ctl, FW_MEM);
        chk("gap_muxb", muxb_fw_ctl, FW_NOP);
    endtask

    task automatic test_load_use();
        ins_t lw;
        idle(2);
        lw = alu(7, 1, 0);
        lw.rtu = 0;
        lw.ld = 1;
        put(lw);
        cyc();
        put(alu(8, 7, 2));
        @(negedge clk);
        chk("lu_pause", {2'b0, pause}, 3'd1);
        chk("lu_bubble", {2'b0, ex_bubble}, 3'd1);
        cyc();
        @(negedge clk);
        chk("lu_pause2", {2'b0, pause}, 3'd0);
        chk("lu_bubble2", {2'b0, ex_bubble}, 3'd0);
        cyc();
        put(nop());
        @(negedge clk);
        chk("lu_muxa", muxa_fw_ctl, FW_MEM);
    endtask

    task automatic test_store_r0();
        ins_t sw;
        idle(2);
        put(alu(9, 1, 2));
        cyc();
        sw = alu(0, 1, 9);
        sw.we = 0;
        sw.st = 1;
        put(sw);
        cyc();
        put(nop());
        @(negedge clk);
        chk("st_dmem", dmem_fw_ctl, FW_ALU);
        chk("st_muxb", muxb_fw_ctl, FW_NOP);
        chk("st_muxa", muxa_fw_ctl, FW_NOP);
        idle(2);
        put(alu(0, 1, 2));
        cyc();
        put(alu(4, 0, 0));
        cyc();
        put(nop());
        @(negedge clk);
        chk("r0_muxa", muxa_fw_ctl, FW_NOP);
        chk("r0_muxb", muxb_fw_ctl, FW_NOP);
    endtask

    task automatic test_muldiv();
        ins_t mu;
        ins_t mf;
        int busy_n = 0;
        idle(2);
        mu = alu(0, 1, 2);
        mu.we = 0;
        mu.md = 1;
        mf = nop();
        mf.v = 1; mf.we = 1; mf.wb = 3; mf.hl = 1;
        put(mu);
        cyc();
        put(mf);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!md_busy) break;
            busy_n++;
            chk("md_pause", {2'b0, pause}, 3'd1);
            cyc();
        end
        chk("md_len", 3'(busy_n), 3'(MDC));
        chk("md_release", {2'b0, pause}, 3'd0);
        cyc();
        put(nop());
        @(negedge clk);
        chk("md_busy_end", {2'b0, md_busy}, 3'd0);
    endtask

    task automatic test_flush_reset();
        ins_t lw;
        ins_t mu;
        ins_t mf;
        idle(2);
        lw = alu(7, 1, 0);
        lw.rtu = 0;
        lw.ld = 1;
        put(lw);
        cyc();
        put(alu(8, 7, 2));
        @(negedge clk);
        chk("fl_pause0", {2'b0, pause}, 3'd1);
        cyc();
        flush = 1;
        @(negedge clk);
        chk("fl_pause1", {2'b0, pause}, 3'd0);
        cyc();
        flush = 0;
        put(nop());
        @(negedge clk);
        chk("fl_pause2", {2'b0, pause}, 3'd0);
        chk("fl_muxa", muxa_fw_ctl, FW_NOP);
        chk("fl_muxb", muxb_fw_ctl, FW_NOP);
        chk("fl_dmem", dmem_fw_ctl, FW_NOP);
        idle(2);
        mu = alu(0, 1, 2);
        mu.we = 0;
        mu.md = 1;
        mf = nop();
        mf.v = 1; mf.we = 1; mf.wb = 3; mf.hl = 1;
        put(mu);
        cyc();
        put(mf);
        @(negedge clk);
        chk("rmd_pause0", {2'b0, pause}, 3'd1);
        #1;
        rst = 1;
        #1;
        chk("rmd_busy", {2'b0, md_busy}, 3'd0);
        chk("rmd_pause", {2'b0, pause}, 3'd0);
        cyc();
        rst = 0;
        idle(2);
    endtask

    function automatic bit hit(bit u, bit [4:0] s, bit we, bit [4:0] d);
        return u && we && s != 0 && s == d;
    endfunction

    task automatic test_random();
        ins_t i;
        bit fl;
        bit ex_we, ex_ld, mem_we;
        bit [4:0] ex_d, mem_d;
        int md_left;
        logic [2:0] ea, eb, ed, ca, ct;
        bit lu, mdh, p, go;
        rst = 1;
        put(nop());
        flush = 0;
        cyc();
        rst = 0;
        ex_we = 0; ex_ld = 0; ex_d = 0;
        mem_we = 0; mem_d = 0;
        md_left = 0;
        ea = FW_NOP; eb = FW_NOP; ed = FW_NOP;
        for (int n = 0; n < 2000; n++) begin
            i = '0;
            i.v   = ($urandom_range(7) != 0);
            i.rs  = 5'($urandom_range(3));
            i.rt  = 5'($urandom_range(3));
            i.rsu = 1'($urandom);
            i.rtu = 1'($urandom);
            i.st  = ($urandom_range(3) == 0);
            i.we  = 1'($urandom);
            i.wb  = 5'($urandom_range(3));
            i.ld  = ($urandom_range(2) == 0);
            i.md  = ($urandom_range(9) == 0);
            i.hl  = ($urandom_range(7) == 0);
            fl    = ($urandom_range(15) == 0);
            put(i);
            flush = fl;
            lu = i.v && ex_ld && (hit(i.rsu, i.rs, ex_we, ex_d)
                               || hit(i.rtu, i.rt, ex_we, ex_d));
            mdh = i.v && (i.md || i.hl) && md_left > 0;
            p = !fl && (lu || mdh);
            @(negedge clk);
            checks++;
            if ({pause, ex_bubble, md_busy} !== {p, p, md_left > 0}) begin
                errors++;
                $display("FAIL rnd_ctl n=%0d got=%b%b%b exp=%b%b%b", n,
                         pause, ex_bubble, md_busy, p, p, md_left > 0);
            end
            checks++;
            if ({muxa_fw_ctl, muxb_fw_ctl, dmem_fw_ctl} !== {ea, eb, ed}) begin
                errors++;
                $display("FAIL rnd_fw n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                         n, muxa_fw_ctl, muxb_fw_ctl, dmem_fw_ctl, ea, eb, ed);
            end
            go = i.v && !p && !fl;
            ca = hit(i.rsu, i.rs, ex_we, ex_d) ? FW_ALU :
                 hit(i.rsu, i.rs, mem_we, mem_d) ? FW_MEM : FW_NOP;
            ct = hit(i.rtu, i.rt, ex_we, ex_d) ? FW_ALU :
                 hit(i.rtu, i.rt, mem_we, mem_d) ? FW_MEM : FW_NOP;
            ea = go ? ca : FW_NOP;
            eb = (go && !i.st) ? ct : FW_NOP;
            ed = (go && i.st) ? ct : FW_NOP;
            if (go && i.md)
                md_left = MDC;
            else if (md_left > 0)
                md_left--;
            mem_we = ex_we;
            mem_d  = ex_d;
            ex_we  = go && i.we;
            ex_d   = go ? i.wb : 5'd0;
            ex_ld  = go && i.ld;
            cyc();
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_one_gap();
        test_load_use();
        test_store_r0();
        test_muldiv();
        test_flush_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
